// File: rtl/intr_controller.sv
// Prioritised interrupt/exception controller: edge-latched requests, fixed-priority
// arbitration, flush/vector-load pulses and EPC capture. Optional nesting via NESTED_INTR_EN.
module intr_controller #(
  parameter int          NUM_EXT      = 4,
  parameter logic [31:0] EXC_VEC      = 32'h0000_0300,
  parameter logic [31:0] INT_VEC_BASE = 32'h0000_0200,
  parameter logic [31:0] INT_VEC_STEP = 32'h0000_0010,
  parameter int          NEST_DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_EXT-1:0] ext_intr,
  input  logic [NUM_EXT-1:0] int_mask,
  input  logic               overflow,
  input  logic [31:0]        IE_PC,
  input  logic               INTS_end,
  output logic               exe_intr,
  output logic               IF_Flush,
  output logic               IE_Flush,
  output logic               EM_Flush,
  output logic               LD_INTS,
  output logic [31:0]        INTS_PC,
  output logic [31:0]        EPC,
  output logic [4:0]         int_id
);

  typedef enum logic [1:0] {IDLE, TAKE, SERVICE} state_t;

  state_t             state, state_nxt;
  logic [NUM_EXT-1:0] ext_intr_p0;
  logic [NUM_EXT:0]   pend, eligible, pend_set, pend_clr;
  logic [4:0]         winner;
  logic               win_vld;
  logic               take, ret;

  function automatic logic [31:0] vector_of(input logic [4:0] id);
    logic [31:0] line;
    line = 32'(id) - 32'd1;
    if (id == 5'd0) vector_of = EXC_VEC;
    else            vector_of = INT_VEC_BASE + line * INT_VEC_STEP;
  endfunction

  assign eligible = pend & {~int_mask, 1'b1};
  assign pend_set = {ext_intr & ~ext_intr_p0, overflow};
  assign pend_clr = take ? ((NUM_EXT+1)'(1) << winner) : '0;

  always_comb begin
    winner  = 5'd0;
    win_vld = 1'b0;
    for (int i = NUM_EXT; i >= 0; i--) begin
      if (eligible[i]) begin
        winner  = 5'(i);
        win_vld = 1'b1;
      end
    end
  end

`ifdef NESTED_INTR_EN
  localparam int SP_W  = $clog2(NEST_DEPTH + 1);
  localparam int STK_N = 1 << SP_W;

  logic [SP_W-1:0] sp;
  logic [31:0]     epc_stk [STK_N];
  logic [4:0]      id_stk  [STK_N];
  logic            push, pop, stk_full;

  assign stk_full = (sp >= SP_W'(NEST_DEPTH));
`else
  localparam int unused_nest_depth = NEST_DEPTH;
`endif

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    ret       = 1'b0;
`ifdef NESTED_INTR_EN
    push      = 1'b0;
    pop       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (win_vld) begin
          take      = 1'b1;
          state_nxt = TAKE;
        end
      end
      TAKE: state_nxt = SERVICE;
      SERVICE: begin
        if (INTS_end) begin
`ifdef NESTED_INTR_EN
          if (sp != '0) begin
            pop = 1'b1;
          end else begin
            ret       = 1'b1;
            state_nxt = IDLE;
          end
`else
          ret       = 1'b1;
          state_nxt = IDLE;
`endif
        end
`ifdef NESTED_INTR_EN
        // Only a strictly higher-priority source may interrupt the current routine.
        else if (win_vld && (winner < int_id) && !stk_full) begin
          push      = 1'b1;
          take      = 1'b1;
          state_nxt = TAKE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign IF_Flush = (state == TAKE);
  assign IE_Flush = (state == TAKE);
  assign EM_Flush = (state == TAKE);
  assign LD_INTS  = (state == TAKE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ext_intr_p0 <= '0;
      pend        <= '0;
      exe_intr    <= 1'b0;
      int_id      <= 5'd0;
      INTS_PC     <= 32'd0;
      EPC         <= 32'd0;
    end else begin
      state       <= state_nxt;
      ext_intr_p0 <= ext_intr;
      // A new request in the same cycle as a take keeps the bit set.
      pend        <= (pend & ~pend_clr) | pend_set;
      if (take) begin
        EPC      <= IE_PC;
        int_id   <= winner;
        INTS_PC  <= vector_of(winner);
        exe_intr <= 1'b1;
      end
`ifdef NESTED_INTR_EN
      else if (pop) begin
        EPC    <= epc_stk[sp - 1'b1];
        int_id <= id_stk[sp - 1'b1];
      end
`endif
      else if (ret) begin
        exe_intr <= 1'b0;
        int_id   <= 5'd0;
      end
    end
  end

`ifdef NESTED_INTR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    sp <= '0;
    else if (push) sp <= sp + 1'b1;
    else if (pop)  sp <= sp - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      epc_stk[sp] <= EPC;
      id_stk[sp]  <= int_id;
    end
  end
`endif

endmodule

// File: tb/tb_intr_controller.sv
// Directed and randomised bench for intr_controller, checked cycle by cycle
// against a behavioural model of the request/service rules.
module tb_intr_controller;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] ext_intr = '0;
  logic [N-1:0] int_mask = '0;
  logic         overflow = 1'b0;
  logic [31:0]  IE_PC = 32'd0;
  logic         INTS_end = 1'b0;
  logic         exe_intr, IF_Flush, IE_Flush, EM_Flush, LD_INTS;
  logic [31:0]  INTS_PC, EPC;
  logic [4:0]   int_id;

  intr_controller #(.NUM_EXT(N)) dut (
    .clk(clk), .rst_n(rst_n), .ext_intr(ext_intr), .int_mask(int_mask),
    .overflow(overflow), .IE_PC(IE_PC), .INTS_end(INTS_end),
    .exe_intr(exe_intr), .IF_Flush(IF_Flush), .IE_Flush(IE_Flush),
    .EM_Flush(EM_Flush), .LD_INTS(LD_INTS), .INTS_PC(INTS_PC),
    .EPC(EPC), .int_id(int_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 take, 2 service
  bit          m_prev [N];
  bit          m_pend [N+1];
  int          m_phase;
  logic [31:0] m_epc, m_vec;
  int          m_id;
  bit          m_exe;
  logic [31:0] s_epc [$];
  int          s_id  [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] vec_of(input int w);
    if (w == 0) return 32'h0000_0300;
    return 32'h0000_0200 + 32'((w - 1) * 16);
  endfunction

  function automatic int m_winner();
    int w = -1;
    for (int i = N; i >= 0; i--)
      if (m_pend[i] && (i == 0 || !int_mask[i-1])) w = i;
    return w;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_prev[i] = 1'b0;
    for (int i = 0; i <= N; i++) m_pend[i] = 1'b0;
    m_phase = 0; m_epc = 0; m_vec = 0; m_id = 0; m_exe = 0;
    s_epc.delete(); s_id.delete();
  endtask

  task automatic m_take(input int w);
    m_phase = 1; m_epc = IE_PC; m_id = w; m_vec = vec_of(w); m_exe = 1;
    m_pend[w] = 1'b0;
  endtask

  task automatic model_step();
    int w = m_winner();
    if (m_phase == 0) begin
      if (w >= 0) m_take(w);
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (INTS_end) begin
`ifdef NESTED_INTR_EN
      if (s_id.size() > 0) begin
        m_epc = s_epc.pop_back();
        m_id  = s_id.pop_back();
      end else
`endif
      begin
        m_phase = 0; m_exe = 0; m_id = 0;
      end
    end
`ifdef NESTED_INTR_EN
    else if (w >= 0 && w < m_id && s_id.size() < 2) begin
      s_epc.push_back(m_epc);
      s_id.push_back(m_id);
      m_take(w);
    end
`endif
    for (int i = 0; i < N; i++) begin
      if (ext_intr[i] && !m_prev[i]) m_pend[i+1] = 1'b1;
      m_prev[i] = ext_intr[i];
    end
    if (overflow) m_pend[0] = 1'b1;
  endtask

  task automatic compare_all();
    chk("IF_Flush", 32'(IF_Flush), 32'(m_phase == 1));
    chk("IE_Flush", 32'(IE_Flush), 32'(m_phase == 1));
    chk("EM_Flush", 32'(EM_Flush), 32'(m_phase == 1));
    chk("LD_INTS",  32'(LD_INTS),  32'(m_phase == 1));
    chk("exe_intr", 32'(exe_intr), 32'(m_exe));
    chk("int_id",   32'(int_id),   32'(m_id));
    chk("INTS_PC",  INTS_PC, m_vec);
    chk("EPC",      EPC, m_epc);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    m_reset();
    #12;
    compare_all();
    rst_n = 1'b1;
    ticks(2);

    // Test 1: single edge on line 2
    IE_PC = 32'h40; ext_intr = 4'b0100;
    tick();
    chk("t1_no_early_take", 32'(LD_INTS), 32'd0);
    tick();
    chk("t1_ld", 32'(LD_INTS), 32'd1);
    chk("t1_vec", INTS_PC, 32'h220);
    chk("t1_epc", EPC, 32'h40);
    chk("t1_id", 32'(int_id), 32'd3);
    tick();
    chk("t1_flush_one_cycle", 32'(IF_Flush), 32'd0);
    ticks(2);
    INTS_end = 1'b1; tick(); INTS_end = 1'b0;
    chk("t1_ret", 32'(exe_intr), 32'd0);
    ext_intr = '0; ticks(2);

    // Test 2: lines 0 and 3 together
    ext_intr = 4'b1001; IE_PC = 32'h100;
    ticks(2);
    chk("t2_first_vec", INTS_PC, 32'h200);
    ticks(2);
    INTS_end = 1'b1; tick(); INTS_end = 1'b0;
    chk("t2_idle_gap", 32'(LD_INTS), 32'd0);
    tick();
    chk("t2_second_vec", INTS_PC, 32'h230);
    chk("t2_second_id", 32'(int_id), 32'd4);
    tick();
    INTS_end = 1'b1; tick(); INTS_end = 1'b0;
    ext_intr = '0; ticks(2);

    // Test 3: overflow beats a masked pending line
    int_mask = 4'hF; ext_intr = 4'b0010;
    ticks(3);
    chk("t3_masked_idle", 32'(exe_intr), 32'd0);
    overflow = 1'b1; IE_PC = 32'h1C; tick(); overflow = 1'b0;
    tick();
    chk("t3_vec", INTS_PC, 32'h300);
    chk("t3_id", 32'(int_id), 32'd0);
    tick();
    INTS_end = 1'b1; tick(); INTS_end = 1'b0;
    ticks(4);
    int_mask = 4'h0;
    ticks(2);
    chk("t3_unmasked_vec", INTS_PC, 32'h210);
    tick();
    INTS_end = 1'b1; tick(); INTS_end = 1'b0;
    ext_intr = '0; ticks(2);

    // Test 4: asynchronous reset in the middle of a service
    ext_intr = 4'b0100; IE_PC = 32'h88;
    ticks(4);
    chk("t4_in_service", 32'(exe_intr), 32'd1);
    #3;
    rst_n = 1'b0; ext_intr = '0;
    m_reset();
    #1;
    compare_all();
    #8;
    rst_n = 1'b1;
    @(posedge clk); #1;
    compare_all();
    ticks(5);
    chk("t4_no_take_after_reset", 32'(exe_intr), 32'd0);

    // Tests 5/6: overflow arrives while line 3 is in service
    ext_intr = 4'b1000; IE_PC = 32'h80;
    ticks(3);
    chk("t56_line3_epc", EPC, 32'h80);
    overflow = 1'b1; IE_PC = 32'h204; tick(); overflow = 1'b0;
    tick();
`ifdef NESTED_INTR_EN
    chk("t5_preempt_vec", INTS_PC, 32'h300);
    chk("t5_preempt_epc", EPC, 32'h204);
    tick();
    INTS_end = 1'b1; tick(); INTS_end = 1'b0;
    chk("t5_pop_epc", EPC, 32'h80);
    chk("t5_pop_id", 32'(int_id), 32'd4);
    chk("t5_pop_exe", 32'(exe_intr), 32'd1);
    tick();
    INTS_end = 1'b1; tick(); INTS_end = 1'b0;
    chk("t5_idle", 32'(exe_intr), 32'd0);
`else
    chk("t6_no_preempt", 32'(int_id), 32'd4);
    tick();
    INTS_end = 1'b1; tick(); INTS_end = 1'b0;
    chk("t6_idle_gap", 32'(exe_intr), 32'd0);
    tick();
    chk("t6_ovf_vec", INTS_PC, 32'h300);
    chk("t6_ovf_epc", EPC, 32'h204);
    tick();
    INTS_end = 1'b1; tick(); INTS_end = 1'b0;
`endif
    ext_intr = '0; ticks(2);

    // Randomised traffic
    for (int c = 0; c < 400; c++) begin
      ext_intr = N'($urandom);
      if ($urandom_range(0, 7) == 0) int_mask = N'($urandom);
      overflow = ($urandom_range(0, 15) == 0);
      INTS_end = ($urandom_range(0, 4) == 0);
      IE_PC    = $urandom;
      tick();
    end
    INTS_end = 1'b0; overflow = 1'b0;
    ticks(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
